lock_msg_composer: RTL and testbench

Formats the digital-lock user interface into the two 16-character ASCII rows consumed by the character-LCD driver. It collects keypad digits into an entry buffer and hands the completed code to the checker on ENTER. It shows check results as timed status messages. It drives `row_1`/`row_2`, where byte [127:120] is the leftmost character.

---
 rtl/lock_msg_composer.sv | 195 +++++++++++++++++++
 tb/tb_lock_msg_composer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lock_msg_composer.sv
// Digital-lock UI composer: keypad entry buffer, code hand-off and timed status rows for a 16x2 LCD.
// Define LOCK_MASK_EN to show entered digits as '*' instead of their ASCII value.
module lock_msg_composer #(
    parameter int unsigned MAX_DIGITS   = 8,
    parameter int unsigned MSG_CYCLES   = 100_000_000,
    parameter int unsigned BLINK_CYCLES = 25_000_000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    input  logic [3:0]   key_code,
    input  logic         st_event_valid,
    input  logic [1:0]   st_event,
    output logic         code_valid,
    output logic [63:0]  code_out,
    output logic [4:0]   code_len,
    output logic [127:0] row_1,
    output logic [127:0] row_2
);

    typedef enum logic [2:0] {StEntry, StCheck, StMsgOk, StMsgFail, StLockout} state_e;

    localparam logic [4:0]   MaxLen = 5'(MAX_DIGITS);
    localparam logic [127:0] Blank  = {16{8'h20}};

    state_e         state_q, state_d;
    logic [4:0]     len_q, len_d;
    logic [63:0]    entry_q, entry_d;
    logic [31:0]    dwell_q, dwell_d;
    logic [31:0]    blink_cnt_q, blink_cnt_d;
    logic           blink_on_q, blink_on_d;
    logic           code_valid_q, code_valid_d;
    logic [63:0]    code_out_q, code_out_d;
    logic [4:0]     code_len_q, code_len_d;
    logic [127:0]   row1_q, row1_d;
    logic [127:0]   row2_q, row2_d;
    logic           key_ok;
    logic           key_accepted;

    // LSB position of digit slot idx (slot 0 is the most significant nibble).
    function automatic logic [5:0] nib_lsb(input logic [4:0] idx);
        return 6'd60 - {idx[3:0], 2'b00};
    endfunction

    // An event in the same cycle always wins over a key.
    assign key_ok = key_valid && !st_event_valid;

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        entry_d      = entry_q;
        dwell_d      = dwell_q;
        code_valid_d = 1'b0;
        code_out_d   = code_out_q;
        code_len_d   = code_len_q;
        key_accepted = 1'b0;
        unique case (state_q)
            StEntry: begin
                if (st_event_valid) begin
                    if (st_event == 2'd2) begin
                        state_d = StLockout;
                        len_d   = '0;
                        entry_d = '0;
                    end
                end else if (key_ok) begin
                    if (key_code <= 4'd9) begin
                        if (len_q < MaxLen) begin
                            entry_d[nib_lsb(len_q) +: 4] = key_code;
                            len_d        = len_q + 5'd1;
                            key_accepted = 1'b1;
                        end
                    end else if (key_code == 4'hA) begin
                        if (len_q != '0) begin
                            entry_d[nib_lsb(len_q - 5'd1) +: 4] = 4'h0;
                            len_d        = len_q - 5'd1;
                            key_accepted = 1'b1;
                        end
                    end else if (key_code == 4'hB) begin
                        len_d        = '0;
                        entry_d      = '0;
                        key_accepted = 1'b1;
                    end else if (key_code == 4'hE) begin
                        if (len_q != '0) begin
                            code_valid_d = 1'b1;
                            code_out_d   = entry_q;
                            code_len_d   = len_q;
                            len_d        = '0;
                            entry_d      = '0;
                            key_accepted = 1'b1;
                            state_d      = StCheck;
                        end
                    end
                end
            end
            StCheck: begin
                dwell_d = '0;
                if (st_event_valid) begin
                    unique case (st_event)
                        2'd0:    state_d = StMsgOk;
                        2'd1:    state_d = StMsgFail;
                        2'd2:    state_d = StLockout;
                        default: state_d = StEntry;
                    endcase
                end
            end
            StMsgOk, StMsgFail: begin
                // Message is visible for MSG_CYCLES+1 cycles, counted from entry into the state.
                if (st_event_valid && st_event == 2'd2) begin
                    state_d = StLockout;
                end else if (dwell_q == MSG_CYCLES) begin
                    state_d = StEntry;
                end else begin
                    dwell_d = dwell_q + 32'd1;
                end
            end
            StLockout: begin
                if (st_event_valid && st_event == 2'd3) state_d = StEntry;
            end
            default: state_d = StEntry;
        endcase
    end

    always_comb begin
        blink_cnt_d = blink_cnt_q + 32'd1;
        blink_on_d  = blink_on_q;
        if (state_q != StEntry || state_d != StEntry || key_accepted) begin
            blink_cnt_d = '0;
            blink_on_d  = 1'b1;
        end else if (blink_cnt_q == BLINK_CYCLES - 1) begin
            blink_cnt_d = '0;
            blink_on_d  = !blink_on_q;
        end
    end

    always_comb begin
        row1_d = Blank;
        row2_d = Blank;
        unique case (state_q)
            StEntry:   row1_d = "ENTER CODE:     ";
            StCheck:   row1_d = "CHECKING...     ";
            StMsgOk:   row1_d = "ACCESS GRANTED  ";
            StMsgFail: row1_d = "WRONG CODE      ";
            StLockout: row1_d = "LOCKED OUT      ";
            default:   row1_d = Blank;
        endcase
        if (state_q == StEntry) begin
            for (int p = 0; p < 16; p++) begin
                if (p < int'(len_q)) begin
`ifdef LOCK_MASK_EN
                    row2_d[8*(15-p) +: 8] = 8'h2A;
`else
                    row2_d[8*(15-p) +: 8] = 8'h30 + {4'h0, entry_q[nib_lsb(5'(p)) +: 4]};
`endif
                end else if (p == int'(len_q) && len_q < MaxLen && blink_on_q) begin
                    row2_d[8*(15-p) +: 8] = 8'h5F;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StEntry;
            len_q        <= '0;
            entry_q      <= '0;
            dwell_q      <= '0;
            blink_cnt_q  <= '0;
            blink_on_q   <= 1'b1;
            code_valid_q <= 1'b0;
            code_out_q   <= '0;
            code_len_q   <= '0;
            row1_q       <= Blank;
            row2_q       <= Blank;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            entry_q      <= entry_d;
            dwell_q      <= dwell_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_on_q   <= blink_on_d;
            code_valid_q <= code_valid_d;
            code_out_q   <= code_out_d;
            code_len_q   <= code_len_d;
            row1_q       <= row1_d;
            row2_q       <= row2_d;
        end
    end

    assign code_valid = code_valid_q;
    assign code_out   = code_out_q;
    assign code_len   = code_len_q;
    assign row_1      = row1_q;
    assign row_2      = row2_q;

endmodule

// File: tb/tb_lock_msg_composer.sv
// Directed plus random bench for lock_msg_composer against a queue-based behavioural model.
module tb_lock_msg_composer;

    localparam int MAXD  = 8;
    localparam int MSG   = 20;
    localparam int BLINK = 7;
    localparam int MEntry = 0, MCheck = 1, MOk = 2, MFail = 3, MLock = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         key_valid = 1'b0;
    logic [3:0]   key_code = 4'h0;
    logic         st_event_valid = 1'b0;
    logic [1:0]   st_event = 2'd0;
    logic         code_valid;
    logic [63:0]  code_out;
    logic [4:0]   code_len;
    logic [127:0] row_1, row_2;

    lock_msg_composer #(
        .MAX_DIGITS  (MAXD),
        .MSG_CYCLES  (MSG),
        .BLINK_CYCLES(BLINK)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .st_event_valid(st_event_valid),
        .st_event      (st_event),
        .code_valid    (code_valid),
        .code_out      (code_out),
        .code_len      (code_len),
        .row_1         (row_1),
        .row_2         (row_2)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Model state
    int          m_mode = MEntry;
    int          m_digits[$];
    int          m_edge = 0;
    int          m_force = 0;
    int          m_msg_start = 0;
    logic [63:0] m_code = '0;
    int          m_len = 0;
    logic        m_cv = 1'b0;

    function automatic logic [127:0] pad16(input string s);
        logic [127:0] r = {16{8'h20}};
        for (int i = 0; i < s.len() && i < 16; i++) r[8*(15-i) +: 8] = s[i];
        return r;
    endfunction

    function automatic logic [127:0] render1(input int mode);
        case (mode)
            MEntry:  return pad16("ENTER CODE:");
            MCheck:  return pad16("CHECKING...");
            MOk:     return pad16("ACCESS GRANTED");
            MFail:   return pad16("WRONG CODE");
            default: return pad16("LOCKED OUT");
        endcase
    endfunction

    function automatic logic [7:0] digit_char(input int d);
`ifdef LOCK_MASK_EN
        return 8'h2A;
`else
        return 8'(8'h30 + d);
`endif
    endfunction

    function automatic logic [127:0] render2();
        logic [127:0] r = {16{8'h20}};
        bit phase_on = (((m_edge - m_force) / BLINK) % 2) == 0;
        if (m_mode != MEntry) return r;
        foreach (m_digits[i]) r[8*(15-i) +: 8] = digit_char(m_digits[i]);
        if (m_digits.size() < MAXD && phase_on) r[8*(15-m_digits.size()) +: 8] = 8'h5F;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit kv, input int kc, input bit ev_v, input int ev);
        int  pre = m_mode;
        bit  acc = 0;
        m_edge++;
        m_cv = 1'b0;
        if (r) begin
            m_mode = MEntry;
            m_digits.delete();
            m_force = m_edge;
            m_code = '0;
            m_len = 0;
            return;
        end
        if (pre == MOk || pre == MFail) begin
            if (ev_v && ev == 2) m_mode = MLock;
            else if (m_edge - m_msg_start == MSG + 1) m_mode = MEntry;
        end else if (ev_v) begin
            if (pre == MEntry && ev == 2) begin
                m_mode = MLock;
                m_digits.delete();
            end else if (pre == MCheck) begin
                m_mode = (ev == 0) ? MOk : (ev == 1) ? MFail : (ev == 2) ? MLock : MEntry;
                m_msg_start = m_edge;
            end else if (pre == MLock && ev == 3) begin
                m_mode = MEntry;
            end
        end else if (kv && pre == MEntry) begin
            if (kc <= 9) begin
                if (m_digits.size() < MAXD) begin
                    m_digits.push_back(kc);
                    acc = 1;
                end
            end else if (kc == 10) begin
                if (m_digits.size() > 0) begin
                    void'(m_digits.pop_back());
                    acc = 1;
                end
            end else if (kc == 11) begin
                m_digits.delete();
                acc = 1;
            end else if (kc == 14 && m_digits.size() > 0) begin
                m_code = '0;
                foreach (m_digits[i]) m_code[4*(15-i) +: 4] = 4'(m_digits[i]);
                m_len = m_digits.size();
                m_cv = 1'b1;
                m_digits.delete();
                m_mode = MCheck;
            end
        end
        if (pre != MEntry || m_mode != MEntry || acc) m_force = m_edge;
    endtask

    // One clock: drive inputs, advance the model, compare all outputs just after the edge.
    task automatic step(input bit r, input bit kv, input int kc, input bit ev_v, input int ev);
        logic [127:0] e1, e2;
        rst = r;
        key_valid = kv;
        key_code = 4'(kc);
        st_event_valid = ev_v;
        st_event = 2'(ev);
        e1 = r ? {16{8'h20}} : render1(m_mode);
        e2 = r ? {16{8'h20}} : render2();
        @(posedge clk);
        model_edge(r, kv, kc, ev_v, ev);
        #1;
        chk("row_1", row_1, e1);
        chk("row_2", row_2, e2);
        chk("code_valid", 128'(code_valid), 128'(m_cv));
        chk("code_out", 128'(code_out), 128'(m_code));
        chk("code_len", 128'(code_len), 128'(m_len));
        rst = 1'b0;
        key_valid = 1'b0;
        st_event_valid = 1'b0;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0);
    endtask

    task automatic key(input int kc);
        step(0, 1, kc, 0, 0);
    endtask

    task automatic event_in(input int ev);
        step(0, 0, 0, 1, ev);
    endtask

    initial begin
        int wrong_cycles;
        int budget;

        // Reset, then 1,2,3
        #2;
        step(1, 0, 0, 0, 0);
        chk("reset_row_1", row_1, {16{8'h20}});
        chk("reset_row_2", row_2, {16{8'h20}});
        idle();
        key(1); key(2); key(3);
        idle();
        chk("entry_row_1", row_1, pad16("ENTER CODE:"));
`ifdef LOCK_MASK_EN
        chk("entry_row_2", row_2, pad16("***_"));
`else
        chk("entry_row_2", row_2, pad16("123_"));
`endif

        // Backspace then Enter
        key(10);
        key(14);
        chk("enter_pulse", 128'(code_valid), 128'(1));
        chk("enter_code", 128'(code_out), 128'(64'h1200_0000_0000_0000));
        chk("enter_len", 128'(code_len), 128'(2));
        idle();
        chk("check_row_1", row_1, pad16("CHECKING..."));
        chk("pulse_once", 128'(code_valid), 128'(0));

        // FAIL message dwell
        event_in(1);
        wrong_cycles = 0;
        budget = 0;
        while (row_1 !== pad16("ENTER CODE:") && budget < 100) begin
            if (row_1 === pad16("WRONG CODE")) wrong_cycles++;
            idle();
            budget++;
        end
        chk("fail_dwell", 128'(wrong_cycles), 128'(MSG + 1));
        chk("after_msg_row_2", row_2, pad16("_"));

        // Overflow entry
        for (int d = 1; d <= 9; d++) key(d);
        idle();
`ifdef LOCK_MASK_EN
        chk("full_row_2", row_2, pad16("********"));
`else
        chk("full_row_2", row_2, pad16("12345678"));
`endif
        key(14);
        chk("full_len", 128'(code_len), 128'(8));
        chk("full_code", 128'(code_out), 128'(64'h1234_5678_0000_0000));
        event_in(3);
        idle();

        // LOCK wins over a simultaneous key
        step(0, 1, 5, 1, 2);
        idle();
        chk("lock_row_1", row_1, pad16("LOCKED OUT"));
        key(5); key(14); event_in(0);
        chk("lock_hold", row_1, pad16("LOCKED OUT"));
        event_in(3);
        idle();
        chk("release_row_2", row_2, pad16("_"));

        // Reset during CHECK
        key(7); key(14); idle();
        step(1, 0, 0, 0, 0);
        chk("rst_row_1", row_1, {16{8'h20}});
        chk("rst_row_2", row_2, {16{8'h20}});
        chk("rst_no_pulse", 128'(code_valid), 128'(0));
        idle();
        chk("rst_entry", row_1, pad16("ENTER CODE:"));

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            bit r  = ($urandom_range(0, 299) == 0);
            bit kv = ($urandom_range(0, 2) == 0);
            bit ev = ($urandom_range(0, 14) == 0);
            int kc = (($urandom_range(0, 3) == 0) ? 14 : $urandom_range(0, 15));
            step(r, kv, kc, ev, $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
